// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 scan driver.
//   state_t            : scan FSM states (also visible on the debug port)
//   PANEL_COLS/ROWS    : default panel geometry, ROW_PAIRS = rows driven per half
//   RED/GREEN/OFF      : 3-bit {R,G,B} colour codes for one panel half
package hub75_pkg;

  typedef enum logic [2:0] {
    SNAP    = 3'd0,
    SHIFT   = 3'd1,
    BLANK   = 3'd2,
    LATCH   = 3'd3,
    DISPLAY = 3'd4
  } state_t;

  localparam int PANEL_COLS = 32;
  localparam int PANEL_ROWS = 16;
  localparam int ROW_PAIRS  = PANEL_ROWS / 2;

  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] GREEN = 3'b010;
  localparam logic [2:0] OFF   = 3'b000;

endpackage

// File: rtl/hub75_pixel_mux.sv
// Combinational pixel lookup for one shift slot.
//   bitmap : snapshot, bitmap[c][r]
//   col    : column being shifted
//   row    : row pair; top half uses row, bottom half uses row + ROWS/2
//   rgb    : {R1,G1,B1,R2,G2,B2}
// Set pixels are red; with BORDER_EN the outer frame is green and wins
// over the bitmap. The border test is made per half, so row pair 0 only
// frames its top half and the last row pair only its bottom half.
module hub75_pixel_mux
  import hub75_pkg::*;
#(
  parameter int COLS      = PANEL_COLS,
  parameter int ROWS      = PANEL_ROWS,
  parameter bit BORDER_EN = 1'b1
) (
  input  logic [COLS-1:0][ROWS-1:0]    bitmap,
  input  logic [$clog2(COLS)-1:0]      col,
  input  logic [$clog2(ROWS/2)-1:0]    row,
  output logic [5:0]                   rgb
);

  localparam int CW = $clog2(COLS);
  localparam int AW = $clog2(ROWS);

  logic [AW-1:0] rt;
  logic [AW-1:0] rb;
  logic          edge_col;
  logic          top_border;
  logic          bot_border;
  logic [2:0]    top_px;
  logic [2:0]    bot_px;

  always_comb begin
    rt         = AW'(row);
    rb         = rt + AW'(ROWS / 2);
    edge_col   = (col == '0) || (col == CW'(COLS - 1));
    top_border = BORDER_EN && (edge_col || (rt == '0));
    bot_border = BORDER_EN && (edge_col || (rb == AW'(ROWS - 1)));
    top_px     = bitmap[col][rt] ? RED : OFF;
    bot_px     = bitmap[col][rb] ? RED : OFF;
    if (top_border) top_px = GREEN;
    if (bot_border) bot_px = GREEN;
    rgb = {top_px, bot_px};
  end

endmodule

// File: rtl/hub75_scan_driver.sv
// Scans a COLS x ROWS bitmap onto a HUB75 panel, two row halves at a time.
//   clk, reset_n : system clock, asynchronous active-low reset
//   matrix       : bitmap, matrix[c][r]; sampled only in SNAP
//   rgb          : {R1,G1,B1,R2,G2,B2} for the column being shifted
//   sclk         : shift clock, panel samples on the rising edge
//   lat          : latch pulse, active high
//   oe           : output enable, active low
//   abc          : row-pair address of the pair being displayed
//   frame_done   : one-cycle pulse as the next frame's SNAP begins
//   dbg_state    : current FSM state
// Per row pair: SHIFT (COLS x 2*SCLK_HALF) -> BLANK -> LATCH -> DISPLAY
// (ON_CYCLES). The previous pair stays lit while the next one shifts in.
// A frame starts with one SNAP cycle that freezes the bitmap so a mid-frame
// change cannot tear the picture.
module hub75_scan_driver
  import hub75_pkg::*;
#(
  parameter int COLS      = PANEL_COLS,
  parameter int ROWS      = PANEL_ROWS,
  parameter int SCLK_HALF = 1,
  parameter int ON_CYCLES = 64,
  parameter bit BORDER_EN = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [COLS-1:0][ROWS-1:0]    matrix,
  output logic [5:0]                   rgb,
  output logic                         sclk,
  output logic                         lat,
  output logic                         oe,
  output logic [$clog2(ROWS/2)-1:0]    abc,
  output logic                         frame_done,
  output state_t                       dbg_state
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS / 2);
  localparam int PW = $clog2(SCLK_HALF) + 1;
  localparam int OW = $clog2(ON_CYCLES) + 1;

  localparam logic [PW-1:0] PH_LAST  = PW'(SCLK_HALF - 1);
  localparam logic [OW-1:0] ON_LAST  = OW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS / 2 - 1);

  state_t                    state;
  logic [RW-1:0]             row;
  logic [CW-1:0]             col;
  logic [PW-1:0]             phase;
  logic [OW-1:0]             on_cnt;
  logic [COLS-1:0][ROWS-1:0] snap;

  // The mux is addressed with the slot about to be entered so rgb can be
  // registered on the same edge that starts the slot's low phase. In SNAP
  // the snapshot is still loading, so the first pixel comes from matrix,
  // which is exactly the value being captured.
  logic [COLS-1:0][ROWS-1:0] pix_src;
  logic [RW-1:0]             pix_row;
  logic [CW-1:0]             pix_col;
  logic [5:0]                pix_rgb;

  always_comb begin
    pix_src = snap;
    pix_row = row;
    pix_col = col + 1'b1;
    case (state)
      SNAP: begin
        pix_src = matrix;
        pix_row = '0;
        pix_col = '0;
      end
      DISPLAY: begin
        pix_row = row + 1'b1;
        pix_col = '0;
      end
      default: ;
    endcase
  end

  hub75_pixel_mux #(
    .COLS      (COLS),
    .ROWS      (ROWS),
    .BORDER_EN (BORDER_EN)
  ) u_pixel_mux (
    .bitmap (pix_src),
    .col    (pix_col),
    .row    (pix_row),
    .rgb    (pix_rgb)
  );

  always_ff @(posedge clk) begin
    if (state == SNAP) snap <= matrix;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= SNAP;
      row        <= '0;
      col        <= '0;
      phase      <= '0;
      on_cnt     <= '0;
      rgb        <= '0;
      sclk       <= 1'b0;
      lat        <= 1'b0;
      oe         <= 1'b1;
      abc        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        SNAP: begin
          col   <= '0;
          phase <= '0;
          sclk  <= 1'b0;
          rgb   <= pix_rgb;
          state <= SHIFT;
        end

        SHIFT: begin
          if (phase != PH_LAST) begin
            phase <= phase + 1'b1;
          end else begin
            phase <= '0;
            if (!sclk) begin
              sclk <= 1'b1;
            end else if (col == COL_LAST) begin
              sclk  <= 1'b0;
              rgb   <= '0;
              oe    <= 1'b1;
              abc   <= row;
              state <= BLANK;
            end else begin
              col  <= col + 1'b1;
              sclk <= 1'b0;
              rgb  <= pix_rgb;
            end
          end
        end

        BLANK: begin
          lat   <= 1'b1;
          state <= LATCH;
        end

        LATCH: begin
          lat    <= 1'b0;
          oe     <= 1'b0;
          on_cnt <= '0;
          state  <= DISPLAY;
        end

        DISPLAY: begin
          if (on_cnt != ON_LAST) begin
            on_cnt <= on_cnt + 1'b1;
          end else if (row == ROW_LAST) begin
            row        <= '0;
            oe         <= 1'b1;
            frame_done <= 1'b1;
            state      <= SNAP;
          end else begin
            row   <= row + 1'b1;
            col   <= '0;
            phase <= '0;
            sclk  <= 1'b0;
            rgb   <= pix_rgb;
            state <= SHIFT;
          end
        end

        default: state <= SNAP;
      endcase
    end
  end

  assign dbg_state = state;

endmodule
